atx_pll_reconfig_arb: RTL and testbench
=======================================

Name: atx_pll_reconfig_arb

Overview:
- Shares the ATX PLL reconfiguration Avalon-MM port between NUM_REQ requesters, using round-robin arbitration.
- Each granted request is a masked read-modify-write (RMW) of one 32-bit PLL register.
- Sits between the PLL reconfig_avmm0 interface and the SDI rate-switch and debug controllers, all in the reconfig clock domain.
- Optionally holds completion until PLL calibration has finished and lock is regained.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- ADDR_W, 11, AVMM address width.
- TIMEOUT_CYC, 1048576, lock-wait timeout in clocks (feature enabled only).

Ports:
- reconfig_clk  in  1  reconfig clock.
- reconfig_reset  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request.
- req_addr  in  NUM_REQ*ADDR_W  flattened register address; requester i at [i*ADDR_W +: ADDR_W].
- req_mask  in  NUM_REQ*32  flattened bit mask; 1 = bit replaced.
- req_wdata  in  NUM_REQ*32  flattened replacement data.
- req_done  out  NUM_REQ  one-cycle completion pulse for the owning requester.
- req_err  out  NUM_REQ  valid with req_done; 1 = lock-wait timeout.
- rd_data  out  32  register value before the write; valid with req_done.
- reconfig_write  out  1  AVMM write.
- reconfig_read  out  1  AVMM read.
- reconfig_address  out  ADDR_W  AVMM address.
- reconfig_writedata  out  32  AVMM write data.
- reconfig_readdata  in  32  AVMM read data.
- reconfig_waitrequest  in  1  AVMM waitrequest.
- pll_cal_busy  in  1  PLL calibration busy (asynchronous).
- pll_locked  in  1  PLL lock (asynchronous).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0.
- pll_cal_busy and pll_locked pass through 2-flop synchronisers before use.
- IDLE: if any req_valid is high, grant the first requester at or after the pointer, wrapping modulo NUM_REQ.
  - Latch that requester's addr, mask and wdata.
  - Set the pointer to grant+1 mod NUM_REQ.
  - Go to RD.
- Requesters hold req_valid and operands stable until their req_done; a request is never preempted.
- RD: reconfig_read=1, reconfig_address=latched addr.
  - Hold while waitrequest=1.
  - In the cycle waitrequest=0, capture readdata; deassert read next cycle; go to WR.
- WR: reconfig_write=1, writedata=(rd & ~mask) | (wdata & mask).
  - Hold while waitrequest=0 is not seen; go to LOCK on the cycle waitrequest=0.
- LOCK: see Optional Feature.
- DONE: pulse req_done[grant] and drive rd_data for exactly one cycle.
  - req_err[grant]=timeout flag.
  - Return to IDLE; a new grant is made in the following cycle at the earliest.
- read and write are never asserted together; at most one AVMM transaction is outstanding.
- mask=0: RD and WR still execute; the written value equals the value read.
- A requester that drops req_valid while granted does not abort the sequence; its req_done is still pulsed.
- Reset mid-transaction: outputs drop to 0 asynchronously; the AVMM transfer is abandoned; no req_done is pulsed.
- Minimum latency with waitrequest low and the feature disabled: grant to req_done = 4 cycles (RD, WR, LOCK, DONE).

Optional Feature:
- Macro: ATX_RECONFIG_LOCK_WAIT_EN.
- Defined:
  - LOCK first waits up to 16 cycles for synced pll_cal_busy=1; no busy within 16 cycles proceeds.
  - It then waits for cal_busy=0 and pll_locked=1 together.
  - A 32-bit counter is cleared on entry to LOCK. If it reaches TIMEOUT_CYC, set the timeout flag and go to DONE.
- Undefined: LOCK lasts one cycle; the timeout flag is always 0; no counter or synchronisers are instantiated.

Test Plan:
- Single RMW: req0 addr=0x104, mask=0x0000_00F0, wdata=0xA5, readdata=0x1234_5678, waitrequest=0 -> read addr 0x104, then write 0x1234_56A8, req_done[0] pulse, rd_data=0x1234_5678.
- waitrequest stretch: waitrequest high 5 cycles on the read and 3 on the write -> read/write held stable exactly that long, writedata correct, single req_done.
- Round robin: req0 and req1 held continuously -> grants alternate 0,1,0,1; with req1 alone after a req1 grant, req1 is granted again.
- mask=0 with readdata=0xDEAD_BEEF -> writedata=0xDEAD_BEEF.
- Reset asserted during RD -> read=0 immediately, busy=0, no req_done; a new request after reset completes normally.
- Feature enabled:
  - cal_busy pulses for 100 cycles, then locked=1 -> req_done about 102+ cycles after the write, req_err=0.
  - With TIMEOUT_CYC=64 and locked held 0 -> req_err=1 at 64 cycles.

Source files
------------

// File: rtl/atx_pll_reconfig_arb.sv
// Round-robin arbiter granting NUM_REQ requesters masked read-modify-write access to the ATX PLL reconfig AVMM port.
// Define ATX_RECONFIG_LOCK_WAIT_EN to hold completion until PLL calibration finishes and lock is regained.
module atx_pll_reconfig_arb #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                      reconfig_clk,
  input  logic                      reconfig_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_mask,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [31:0]               rd_data,
  output logic                      reconfig_write,
  output logic                      reconfig_read,
  output logic [ADDR_W-1:0]         reconfig_address,
  output logic [31:0]               reconfig_writedata,
  input  logic [31:0]               reconfig_readdata,
  input  logic                      reconfig_waitrequest,
  input  logic                      pll_cal_busy,
  input  logic                      pll_locked,
  output logic                      busy
);

  localparam int          PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_LOCK,
    S_DONE
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] cand;
  logic             pick_ok;
  logic [31:0]      mask_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rd_q;

`ifdef ATX_RECONFIG_LOCK_WAIT_EN
  logic        cal_meta, cal_s;
  logic        lock_meta, lock_s;
  logic [31:0] lock_cnt;
  logic        armed;

  always_ff @(posedge reconfig_clk or posedge reconfig_reset) begin
    if (reconfig_reset) begin
      cal_meta  <= 1'b0;
      cal_s     <= 1'b0;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      cal_meta  <= pll_cal_busy;
      cal_s     <= cal_meta;
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, pll_cal_busy, pll_locked, TO_LAST};
`endif

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!pick_ok && req_valid[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge reconfig_clk or posedge reconfig_reset) begin
    if (reconfig_reset) begin
      state              <= S_IDLE;
      ptr                <= '0;
      grant              <= '0;
      mask_q             <= '0;
      wdata_q            <= '0;
      rd_q               <= '0;
      req_done           <= '0;
      req_err            <= '0;
      rd_data            <= '0;
      reconfig_write     <= 1'b0;
      reconfig_read      <= 1'b0;
      reconfig_address   <= '0;
      reconfig_writedata <= '0;
      busy               <= 1'b0;
`ifdef ATX_RECONFIG_LOCK_WAIT_EN
      lock_cnt           <= '0;
      armed              <= 1'b0;
`endif
    end else begin
      req_done <= '0;
      req_err  <= '0;
      rd_data  <= '0;
      case (state)
        S_IDLE: begin
          if (pick_ok) begin
            grant            <= pick;
            reconfig_address <= req_addr[pick*ADDR_W +: ADDR_W];
            mask_q           <= req_mask[pick*32 +: 32];
            wdata_q          <= req_wdata[pick*32 +: 32];
            ptr              <= (pick == PTR_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
            reconfig_read    <= 1'b1;
            busy             <= 1'b1;
            state            <= S_RD;
          end
        end
        S_RD: begin
          if (!reconfig_waitrequest) begin
            rd_q               <= reconfig_readdata;
            reconfig_writedata <= (reconfig_readdata & ~mask_q) | (wdata_q & mask_q);
            reconfig_read      <= 1'b0;
            reconfig_write     <= 1'b1;
            state              <= S_WR;
          end
        end
        S_WR: begin
          if (!reconfig_waitrequest) begin
            reconfig_write <= 1'b0;
            state          <= S_LOCK;
`ifdef ATX_RECONFIG_LOCK_WAIT_EN
            lock_cnt       <= '0;
            armed          <= 1'b0;
`endif
          end
        end
        S_LOCK: begin
`ifdef ATX_RECONFIG_LOCK_WAIT_EN
          // armed: calibration start was seen, or 16 cycles passed without it
          lock_cnt <= lock_cnt + 32'd1;
          if (lock_cnt == TO_LAST) begin
            req_done[grant] <= 1'b1;
            req_err[grant]  <= 1'b1;
            rd_data         <= rd_q;
            state           <= S_DONE;
          end else if (armed && !cal_s && lock_s) begin
            req_done[grant] <= 1'b1;
            rd_data         <= rd_q;
            state           <= S_DONE;
          end else if (!armed && (cal_s || lock_cnt == 32'd15)) begin
            armed <= 1'b1;
          end
`else
          req_done[grant] <= 1'b1;
          rd_data         <= rd_q;
          state           <= S_DONE;
`endif
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          reconfig_read  <= 1'b0;
          reconfig_write <= 1'b0;
          busy           <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atx_pll_reconfig_arb.sv
// Directed self-checking bench for atx_pll_reconfig_arb with a small AVMM slave and completion monitor.
module tb_atx_pll_reconfig_arb;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 11;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*32-1:0]     req_mask = '0;
  logic [NUM_REQ*32-1:0]     req_wdata = '0;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  logic [31:0]               rd_data;
  logic                      wr;
  logic                      rd;
  logic [ADDR_W-1:0]         addr;
  logic [31:0]               wd;
  logic [31:0]               slave_rdata = '0;
  logic                      waitreq = 1'b0;
  logic                      pll_cal_busy = 1'b0;
  logic                      pll_locked = 1'b1;
  logic                      busy;

  always #5 clk = ~clk;

  atx_pll_reconfig_arb #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(64)
  ) dut (
    .reconfig_clk        (clk),
    .reconfig_reset      (rst),
    .req_valid           (req_valid),
    .req_addr            (req_addr),
    .req_mask            (req_mask),
    .req_wdata           (req_wdata),
    .req_done            (req_done),
    .req_err             (req_err),
    .rd_data             (rd_data),
    .reconfig_write      (wr),
    .reconfig_read       (rd),
    .reconfig_address    (addr),
    .reconfig_writedata  (wd),
    .reconfig_readdata   (slave_rdata),
    .reconfig_waitrequest(waitreq),
    .pll_cal_busy        (pll_cal_busy),
    .pll_locked          (pll_locked),
    .busy                (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave and monitor state, updated on the falling edge
  int          stall_rd = 0, stall_wr = 0;
  int          rd_run = 0, wr_run = 0;
  int          rd_cycles = 0, wr_cycles = 0;
  int          cyc = 0, rd_start_cyc = 0, wr_end_cyc = 0, done_cyc = 0;
  int          done_cnt[NUM_REQ];
  int          both_cnt = 0, unstable_cnt = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
  logic [31:0] last_done_data = '0, prev_wd = '0;
  logic        last_err = 1'b0;
  int          grant_log[$];

  initial begin
    for (int i = 0; i < NUM_REQ; i++) done_cnt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rd_run  = 0;
        wr_run  = 0;
        waitreq = 1'b0;
      end else begin
        if (rd && wr) both_cnt++;
        if (rd) begin
          if (rd_run == 0) rd_start_cyc = cyc;
          rd_run++;
          if (rd_run <= stall_rd) waitreq = 1'b1;
          else begin
            waitreq      = 1'b0;
            rd_cycles    = rd_run;
            rd_run       = 0;
            last_rd_addr = 32'(addr);
          end
        end else if (wr) begin
          if (wr_run == 0) prev_wd = wd;
          else if (wd !== prev_wd) unstable_cnt++;
          wr_run++;
          if (wr_run <= stall_wr) waitreq = 1'b1;
          else begin
            waitreq      = 1'b0;
            wr_cycles    = wr_run;
            wr_run       = 0;
            last_wr_data = wd;
            last_wr_addr = 32'(addr);
            wr_end_cyc   = cyc;
          end
        end else begin
          waitreq = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_done[i]) begin
            done_cnt[i]++;
            grant_log.push_back(i);
            last_done_data = rd_data;
            last_err       = req_err[i];
            done_cyc       = cyc;
          end
        end
      end
    end
  end

  task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] m,
                        input logic [31:0] w, input int budget, output bit ok);
    int start;
    start = done_cnt[i];
    req_addr[i*ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
    req_mask[i*32 +: 32]         = m;
    req_wdata[i*32 +: 32]        = w;
    req_valid[i]                 = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt[i] != start) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int total;
    int dropped;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_read", 32'(rd), 32'd0);
    check_eq("rst_write", 32'(wr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(req_done), 32'd0);
    check_eq("rst_err", 32'(req_err), 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    check_eq("rst_wdata", wd, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // Single RMW
    slave_rdata = 32'h1234_5678;
    do_req(0, 32'h104, 32'h0000_00F0, 32'h0000_00A5, 100, ok);
    check_eq("rmw_done", 32'(ok), 32'd1);
    check_eq("rmw_rd_addr", last_rd_addr, 32'h104);
    check_eq("rmw_wr_addr", last_wr_addr, 32'h104);
    check_eq("rmw_wdata", last_wr_data, 32'h1234_56A8);
    check_eq("rmw_rd_data", last_done_data, 32'h1234_5678);
    check_eq("rmw_err", 32'(last_err), 32'd0);
    check_eq("rmw_rd_cycles", 32'(rd_cycles), 32'd1);
    check_eq("rmw_wr_cycles", 32'(wr_cycles), 32'd1);
`ifdef ATX_RECONFIG_LOCK_WAIT_EN
    check_eq("rmw_latency", 32'(done_cyc - rd_start_cyc), 32'd19);
`else
    check_eq("rmw_latency", 32'(done_cyc - rd_start_cyc), 32'd3);
`endif
    check_eq("rmw_busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check_eq("rmw_busy_idle", 32'(busy), 32'd0);
    check_eq("rmw_done_pulse", 32'(req_done), 32'd0);
    check_eq("rmw_rd_data_clr", rd_data, 32'd0);

    // waitrequest stretch on requester 1
    stall_rd = 5;
    stall_wr = 3;
    slave_rdata = 32'h1111_2222;
    total = done_cnt[1];
    do_req(1, 32'h2A0, 32'hFFFF_0000, 32'hCAFE_0000, 100, ok);
    check_eq("wait_done", 32'(ok), 32'd1);
    check_eq("wait_rd_cycles", 32'(rd_cycles), 32'd6);
    check_eq("wait_wr_cycles", 32'(wr_cycles), 32'd4);
    check_eq("wait_wdata", last_wr_data, 32'hCAFE_2222);
    check_eq("wait_wd_stable", 32'(unstable_cnt), 32'd0);
    check_eq("wait_rd_data", last_done_data, 32'h1111_2222);
    repeat (10) @(negedge clk);
    #1;
    check_eq("wait_single_done", 32'(done_cnt[1] - total), 32'd1);
    stall_rd = 0;
    stall_wr = 0;

    // Round robin: both held, then requester 1 alone after its own grant
    grant_log.delete();
    slave_rdata = 32'h0000_0001;
    req_mask  = '0;
    req_wdata = '0;
    req_valid = 2'b11;
    dropped = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (grant_log.size() >= 4 && dropped == 0) begin
        req_valid[0] = 1'b0;
        dropped = 1;
      end
      if (grant_log.size() >= 5) break;
    end
    req_valid = '0;
    check_eq("rr_count", 32'(grant_log.size()), 32'd5);
    if (grant_log.size() >= 5) begin
      check_eq("rr_g0", 32'(grant_log[0]), 32'd0);
      check_eq("rr_g1", 32'(grant_log[1]), 32'd1);
      check_eq("rr_g2", 32'(grant_log[2]), 32'd0);
      check_eq("rr_g3", 32'(grant_log[3]), 32'd1);
      check_eq("rr_g4_repeat", 32'(grant_log[4]), 32'd1);
    end
    repeat (3) @(negedge clk);
    #1;

    // mask = 0 leaves the register unchanged
    slave_rdata = 32'hDEAD_BEEF;
    do_req(0, 32'h3FF, 32'h0, 32'hFFFF_FFFF, 100, ok);
    check_eq("mask0_done", 32'(ok), 32'd1);
    check_eq("mask0_wdata", last_wr_data, 32'hDEAD_BEEF);
    check_eq("mask0_rd_data", last_done_data, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    #1;

    // Reset during RD
    stall_rd = 10;
    total = done_cnt[0] + done_cnt[1];
    req_addr[0 +: ADDR_W] = 11'h055;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (rd) break;
    end
    check_eq("mid_read_active", 32'(rd), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_read", 32'(rd), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(req_done), 32'd0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    stall_rd = 0;
    repeat (5) @(negedge clk);
    #1;
    check_eq("mid_no_done", 32'(done_cnt[0] + done_cnt[1] - total), 32'd0);
    check_eq("mid_idle_read", 32'(rd), 32'd0);
    slave_rdata = 32'h0F0F_0F0F;
    do_req(1, 32'h010, 32'hFF00_FF00, 32'h1234_5678, 100, ok);
    check_eq("post_rst_done", 32'(ok), 32'd1);
    check_eq("post_rst_wdata", last_wr_data, 32'h120F_560F);
    check_eq("post_rst_rd_data", last_done_data, 32'h0F0F_0F0F);
    check_eq("no_rd_wr_overlap", 32'(both_cnt), 32'd0);
    repeat (2) @(negedge clk);
    #1;

`ifdef ATX_RECONFIG_LOCK_WAIT_EN
    // Calibration pulse, then lock
    slave_rdata = 32'h0000_00FF;
    pll_cal_busy = 1'b1;
    fork
      do_req(0, 32'h020, 32'h0000_000F, 32'h0000_0003, 400, ok);
      begin
        repeat (45) @(negedge clk);
        pll_cal_busy = 1'b0;
      end
    join
    check_eq("cal_done", 32'(ok), 32'd1);
    check_eq("cal_err", 32'(last_err), 32'd0);
    check_eq("cal_wait_long", 32'((done_cyc - wr_end_cyc) >= 40), 32'd1);
    check_eq("cal_wdata", last_wr_data, 32'h0000_00F3);
    repeat (2) @(negedge clk);
    #1;

    // Lock never regained: timeout after 64 LOCK cycles
    pll_locked = 1'b0;
    do_req(1, 32'h030, 32'h0, 32'h0, 400, ok);
    check_eq("to_done", 32'(ok), 32'd1);
    check_eq("to_err", 32'(last_err), 32'd1);
    check_eq("to_latency", 32'(done_cyc - wr_end_cyc), 32'd65);
    pll_locked = 1'b1;
    repeat (2) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
